pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Hazard and stall sequencer for the RV32 5-stage pipeline. It generates the hold (bubble) and clear controls for the PC, IF/ID, ID/EX and EX/MEM pipeline registers. It resolves load-use hazards (with configurable load latency), taken-branch/jump redirects, and multi-cycle EX operations. It also keeps saturating stall and flush performance counters.

Parameters:
LOAD_LAT, 1, stall cycles inserted per load-use hazard (1..7)
CNT_W, 16, width of stall/flush performance counters

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  reset, synchronous, active-high
d_rs1  in  5  rs1 index of instruction in ID
d_rs2  in  5  rs2 index of instruction in ID
d_use_rs1  in  1  ID instruction reads rs1
d_use_rs2  in  1  ID instruction reads rs2
e_rd  in  5  rd of instruction in EX
e_regwen  in  1  EX instruction writes rd
e_is_load  in  1  EX instruction is a load (WBsel = memory)
e_redirect  in  1  EX resolved taken branch/jump; PC being redirected
mc_start  in  1  multi-cycle op entered EX this cycle
mc_done  in  1  multi-cycle unit result valid this cycle
cnt_clr  in  1  synchronous clear of both counters
hold_pc  out  1  PC register holds
hold_fd  out  1  IF/ID bubble (hold)
clear_fd  out  1  IF/ID clear (flush to zero)
hold_de  out  1  ID/EX bubble (hold)
clear_de  out  1  ID/EX clear (insert NOP)
clear_em  out  1  EX/MEM clear (insert NOP)
state  out  2  current FSM state, debug
stall_cnt  out  CNT_W  cycles with hold_pc=1, saturating
flush_cnt  out  CNT_W  redirects acted on, saturating
proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Control outputs are combinational (Mealy) from state and inputs, and valid in the same cycle. Pipeline registers sample them on the next posedge. State, counters and proto_err are registered.
- Reset (rst=1 at posedge): state=RUN, lu_cnt=0, stall_cnt=0, flush_cnt=0, proto_err=0. While rst=1, all control outputs are 0.
- lu_hit = e_is_load & e_regwen & (e_rd!=0) & ((d_use_rs1 & d_rs1==e_rd) | (d_use_rs2 & d_rs2==e_rd)).
- States: RUN=0, LU_STALL=1, MC_BUSY=2. Encoding 3 is unreachable; if reached, treat as RUN.
- RUN, priority order:
  1) mc_start: hold_pc, hold_fd, hold_de, clear_em = 1. If mc_done is also 1 (single-cycle op), drive all 0 and stay in RUN; otherwise go to MC_BUSY.
  2) e_redirect: clear_fd=1, clear_de=1, all holds 0, flush_cnt++.
  3) lu_hit: hold_pc=1, hold_fd=1, clear_de=1. If LOAD_LAT>1, load lu_cnt=LOAD_LAT-1 and go to LU_STALL; else stay in RUN.
  4) Otherwise all outputs 0.
- LU_STALL: hold_pc=1, hold_fd=1, clear_de=1; decrement lu_cnt; return to RUN in the cycle lu_cnt==1. e_redirect in this state aborts the stall: apply redirect outputs, flush_cnt++, go to RUN.
- MC_BUSY:
  - mc_done=0: hold_pc, hold_fd, hold_de, clear_em = 1.
  - mc_done=1: all outputs 0, go to RUN (result advances to EX/MEM at this edge).
  - e_redirect and lu_hit are ignored in this state.
- Never assert a hold and a clear on the same register in the same cycle.
- proto_err is set (sticky until rst) on any of:
  - mc_start & e_redirect in the same cycle (mc wins);
  - mc_start while in MC_BUSY;
  - mc_done while in RUN without mc_start.
- Counters:
  - stall_cnt increments each cycle hold_pc=1.
  - flush_cnt increments once per acted-on redirect.
  - Both saturate at all-ones.
  - cnt_clr zeroes both and takes priority over an increment in the same cycle.
- Reset mid-operation (any state) returns to RUN at the next edge; no partial stall remains.

Test Plan:
- Load-use, LOAD_LAT=1: EX lw x5 (e_is_load=1, e_rd=5), ID add using rs1=5 -> one cycle of hold_pc=hold_fd=clear_de=1, state stays 0, stall_cnt=1.
- Load-use, LOAD_LAT=3: same stimulus -> 3 consecutive stall cycles, state 0→1→1→0, stall_cnt=3. Same case with e_rd=0 -> no stall.
- Redirect: e_redirect=1 in RUN -> clear_fd=clear_de=1 for one cycle, flush_cnt=1. Redirect on the 2nd cycle of an LU_STALL (LOAD_LAT=3) -> stall aborts, state=0, stall_cnt=2, flush_cnt=1.
- Multi-cycle: mc_start with mc_done asserted 5 cycles later -> hold_pc/hold_fd/hold_de/clear_em=1 for 5 cycles, 0 on the done cycle, stall_cnt=5. mc_start & mc_done same cycle -> no stall.
- Protocol and reset: mc_start & e_redirect together -> MC_BUSY entered, proto_err=1 until rst. rst asserted in MC_BUSY -> next cycle state=0, counters 0, outputs 0.
- Saturation: CNT_W=4, 20 stall cycles -> stall_cnt=15. cnt_clr during a stall cycle -> stall_cnt=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - RV32 5-stage hazard/stall sequencer
// Mealy control outputs from state and inputs; state, counters and proto_err are registered.
module pipe_hazard_ctrl #(
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       d_rs1,
   input  logic [4:0]       d_rs2,
   input  logic             d_use_rs1,
   input  logic             d_use_rs2,
   input  logic [4:0]       e_rd,
   input  logic             e_regwen,
   input  logic             e_is_load,
   input  logic             e_redirect,
   input  logic             mc_start,
   input  logic             mc_done,
   input  logic             cnt_clr,
   output logic             hold_pc,
   output logic             hold_fd,
   output logic             clear_fd,
   output logic             hold_de,
   output logic             clear_de,
   output logic             clear_em,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             proto_err
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      MC_BUSY  = 2'd2,
      ST_BAD   = 2'd3
   } st_t;

   localparam logic [2:0] LU_INIT = 3'(LOAD_LAT - 1);

   st_t             st_q, st_d;
   logic [2:0]      lu_q, lu_d;
   logic            lu_hit;
   logic            flush_evt;
   logic            perr_evt;
   logic            h_pc, h_fd, c_fd, h_de, c_de, c_em;
   logic [CNT_W-1:0] stall_q, flush_q;
   logic            perr_q;

   assign lu_hit = e_is_load & e_regwen & (e_rd != 5'd0) &
                   ((d_use_rs1 & (d_rs1 == e_rd)) | (d_use_rs2 & (d_rs2 == e_rd)));

   always_comb begin
      st_d      = st_q;
      lu_d      = lu_q;
      flush_evt = 1'b0;
      perr_evt  = 1'b0;
      h_pc      = 1'b0;
      h_fd      = 1'b0;
      c_fd      = 1'b0;
      h_de      = 1'b0;
      c_de      = 1'b0;
      c_em      = 1'b0;
      case (st_q)
         LU_STALL: begin
            if (e_redirect) begin
               c_fd      = 1'b1;
               c_de      = 1'b1;
               flush_evt = 1'b1;
               lu_d      = 3'd0;
               st_d      = RUN;
            end else begin
               h_pc = 1'b1;
               h_fd = 1'b1;
               c_de = 1'b1;
               lu_d = lu_q - 3'd1;
               if (lu_q <= 3'd1) st_d = RUN;
            end
         end
         MC_BUSY: begin
            perr_evt = mc_start;
            if (mc_done) begin
               st_d = RUN;
            end else begin
               h_pc = 1'b1;
               h_fd = 1'b1;
               h_de = 1'b1;
               c_em = 1'b1;
            end
         end
         default: begin
            // RUN; the unused encoding behaves the same and falls back to RUN
            st_d     = RUN;
            perr_evt = (mc_start & e_redirect) | (mc_done & ~mc_start);
            if (mc_start) begin
               if (!mc_done) begin
                  h_pc = 1'b1;
                  h_fd = 1'b1;
                  h_de = 1'b1;
                  c_em = 1'b1;
                  st_d = MC_BUSY;
               end
            end else if (e_redirect) begin
               c_fd      = 1'b1;
               c_de      = 1'b1;
               flush_evt = 1'b1;
            end else if (lu_hit) begin
               h_pc = 1'b1;
               h_fd = 1'b1;
               c_de = 1'b1;
               if (LOAD_LAT > 1) begin
                  lu_d = LU_INIT;
                  st_d = LU_STALL;
               end
            end
         end
      endcase
      if (rst) begin
         h_pc      = 1'b0;
         h_fd      = 1'b0;
         c_fd      = 1'b0;
         h_de      = 1'b0;
         c_de      = 1'b0;
         c_em      = 1'b0;
         flush_evt = 1'b0;
         perr_evt  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q    <= RUN;
         lu_q    <= 3'd0;
         stall_q <= '0;
         flush_q <= '0;
         perr_q  <= 1'b0;
      end else begin
         st_q <= st_d;
         lu_q <= lu_d;
         if (perr_evt) perr_q <= 1'b1;
         // clear wins over a same-cycle increment
         if (cnt_clr) begin
            stall_q <= '0;
            flush_q <= '0;
         end else begin
            if (h_pc && (stall_q != {CNT_W{1'b1}})) stall_q <= stall_q + 1'b1;
            if (flush_evt && (flush_q != {CNT_W{1'b1}})) flush_q <= flush_q + 1'b1;
         end
      end
   end

   assign hold_pc   = h_pc;
   assign hold_fd   = h_fd;
   assign clear_fd  = c_fd;
   assign hold_de   = h_de;
   assign clear_de  = c_de;
   assign clear_em  = c_em;
   assign state     = st_q;
   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
   assign proto_err = perr_q;

endmodule
